kicker_ctrl: RTL

Parametrised successor to the single-channel kicker: drives the capacitor charger enable and the solenoid discharge trigger from a host kick command. It adds an arm/disarm input, selectable kick strength (pulse width), a post-kick cooldown, kick edge qualification and, optionally, a charge-timeout fault. It sits between the motion/strategy logic (`kick`, `strength`, `arm`) and the kicker board (`done` in; `charge`, `trigger` out).

---
 rtl/kicker_pkg.sv | 29 ++
 rtl/kicker_timer.sv | 16 +
 rtl/kicker_ctrl.sv | 75 +++++++
 3 files changed

// File: rtl/kicker_pkg.sv
// kicker_pkg: kicker FSM state encoding and timer-width helpers.
package kicker_pkg;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CHARGING = 3'd1;
  localparam logic [2:0] S_READY = 3'd2;
  localparam logic [2:0] S_FIRE = 3'd3;
  localparam logic [2:0] S_COOLDOWN = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;
  typedef enum logic [2:0] {
    IDLE = S_IDLE,
    CHARGING = S_CHARGING,
    READY = S_READY,
    FIRE = S_FIRE,
    COOLDOWN = S_COOLDOWN,
    FAULT = S_FAULT
  } kick_state_t;
  function automatic int clog2(input longint v);
    int r = 0;
    for (longint x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction
  // Wide enough to hold the largest value ever loaded into the timer.
  function automatic int cnt_width(input int sw, input longint pulse, input longint cool, input longint tmo);
    longint m = (longint'(1) << sw) * pulse;
    m = cool > m ? cool : m;
    m = tmo > m ? tmo : m;
    return clog2(m) + 1;
  endfunction
endpackage

// File: rtl/kicker_timer.sv
// kicker_timer: loadable down-counter that flags expiry at a count of 1.
module kicker_timer #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= load ? value : cnt != '0 ? cnt - W'(1) : cnt;
  assign expired = cnt == W'(1);
endmodule

// File: rtl/kicker_ctrl.sv
// kicker_ctrl: kicker charge/fire sequencer with arm, strength and cooldown.
// Defining KICKER_CHARGE_TIMEOUT_EN adds a sticky charge-timeout FAULT state.
module kicker_ctrl
  import kicker_pkg::*;
#(
  parameter int STRENGTH_W = 4,
  parameter int PULSE_UNIT = 4096,
  parameter int COOLDOWN_CYCLES = 65536,
  parameter int TIMEOUT_CYCLES = 1 << 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  kick,
  input  logic [STRENGTH_W-1:0] strength,
  input  logic                  arm,
  input  logic                  done,
  output logic                  charge,
  output logic                  trigger,
  output logic                  ready,
  output logic                  fault
);
`ifdef KICKER_CHARGE_TIMEOUT_EN
  localparam longint TMO = TIMEOUT_CYCLES;
`else
  localparam longint TMO = 0;
`endif
  localparam int CNT_W = cnt_width(STRENGTH_W, PULSE_UNIT, COOLDOWN_CYCLES, TMO);
  kick_state_t state, state_nx;
  logic kick_q, kick_rise, expired, load;
  logic [CNT_W-1:0] load_val;
  assign kick_rise = kick & ~kick_q;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = arm ? CHARGING : IDLE;
`ifdef KICKER_CHARGE_TIMEOUT_EN
      CHARGING: state_nx = !arm ? IDLE : done ? READY : expired ? FAULT : CHARGING;
      FAULT: state_nx = arm ? FAULT : IDLE;
`else
      CHARGING: state_nx = !arm ? IDLE : done ? READY : CHARGING;
`endif
      READY: state_nx = !arm ? IDLE : kick_rise ? FIRE : READY;
      FIRE: state_nx = expired ? COOLDOWN : FIRE;
      COOLDOWN: state_nx = !expired ? COOLDOWN : arm ? CHARGING : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // The timer is reloaded on every state change; strength is captured in the pulse length.
  assign load = state_nx != state;
  assign load_val = state_nx == FIRE ? (CNT_W'(strength) + CNT_W'(1)) * CNT_W'(PULSE_UNIT)
                  : state_nx == COOLDOWN ? CNT_W'(COOLDOWN_CYCLES) : CNT_W'(TMO);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      kick_q <= 1'b0;
    end else begin
      state <= state_nx;
      kick_q <= kick;
    end
  kicker_timer #(.W(CNT_W)) u_timer (
    .clk(clk),
    .reset_n(reset_n),
    .load(load),
    .value(load_val),
    .expired(expired)
  );
  assign charge = state == CHARGING || state == READY;
  assign trigger = state == FIRE;
  assign ready = state == READY;
`ifdef KICKER_CHARGE_TIMEOUT_EN
  assign fault = state == FAULT;
`else
  assign fault = 1'b0;
`endif
endmodule
